// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- hazard unit for the 5-stage F/D/E/M/W core.
//
// Purpose:
//   * M/W -> E operand forwarding (M has priority, x0 never forwarded).
//   * Load-use stall: one-cycle F/D hold plus a bubble into E.
//   * Branch/jump redirect flush, optionally stretched by REDIRECT_LAT extra
//     cycles for instruction memories with fetch latency.
//   * Multi-cycle execute ops: freeze F/D/E and bubble M until mc_done.
//
// Parameters:
//   REG_AW       register-index width
//   NUM_SRC      source operands checked per instruction
//   REDIRECT_LAT extra invalid fetch cycles after a redirect (0..7)
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   rs_d, rs_e            packed source indices, operand k at [k*REG_AW +: REG_AW]
//   rd_e, memtoreg_e      E-stage destination / E holds a load
//   rd_m, regwrite_m      M-stage destination / writes regfile
//   rd_w, regwrite_w      W-stage destination / writes regfile
//   pcsrc_e               taken branch/jump in E
//   mc_start_e, mc_done   multi-cycle op start / result-valid pulse
//   fwd_e                 per-operand select: 00 regfile, 01 W, 10 M
//   stall_f/d/e           hold PC, F/D, D/E
//   flush_d/e/m           clear F/D, D/E, E/M
//   mc_busy               FSM in MC_WAIT
//   dbg_state             current FSM state (0 RUN, 1 REDIRECT, 2 MC_WAIT)
//
// Optional feature macro: HAZ_PERF_CNT_EN
//   Adds stall_cnt (cycles with stall_f) and flush_cnt (cycles with flush_d),
//   32-bit wrapping counters.
//
// Handshake: mc_start_e is a one-cycle pulse taken in RUN when no redirect is
// in progress; mc_done is a one-cycle pulse that only has effect in MC_WAIT.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int NUM_SRC      = 2,
    parameter int REDIRECT_LAT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] rs_d,
    input  logic [NUM_SRC*REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0]         rd_e,
    input  logic                      memtoreg_e,
    input  logic [REG_AW-1:0]         rd_m,
    input  logic                      regwrite_m,
    input  logic [REG_AW-1:0]         rd_w,
    input  logic                      regwrite_w,
    input  logic                      pcsrc_e,
    input  logic                      mc_start_e,
    input  logic                      mc_done,
    output logic [NUM_SRC*2-1:0]      fwd_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_e,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      flush_m,
    output logic                      mc_busy,
    output logic [1:0]                dbg_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_MC_WAIT  = 2'd2
    } state_e;

    // Flush counter is 3 bits; REDIRECT_LAT above 7 is not supported.
    localparam logic [2:0] LAT3 = 3'(REDIRECT_LAT);

    state_e       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;

    logic [NUM_SRC*2-1:0] fwd_c;
    logic                 load_use;
    logic stall_f_c, stall_d_c, stall_e_c;
    logic flush_d_c, flush_e_c, flush_m_c, mc_busy_c;

    // Forwarding: independent of FSM state.
    always_comb begin
        fwd_c = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (regwrite_m && (rd_m != '0) && (rd_m == rs_e[k*REG_AW +: REG_AW]))
                fwd_c[k*2 +: 2] = 2'b10;
            else if (regwrite_w && (rd_w != '0) && (rd_w == rs_e[k*REG_AW +: REG_AW]))
                fwd_c[k*2 +: 2] = 2'b01;
        end
    end

    // Load-use: a load in E whose destination feeds any D-stage source.
    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (memtoreg_e && (rd_e != '0) && (rd_e == rs_d[k*REG_AW +: REG_AW]))
                load_use = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_f_c = 1'b0;
        stall_d_c = 1'b0;
        stall_e_c = 1'b0;
        flush_d_c = 1'b0;
        flush_e_c = 1'b0;
        flush_m_c = 1'b0;
        mc_busy_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pcsrc_e) begin
                    // Redirect wins over load-use and a coincident mc start.
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                    if (REDIRECT_LAT > 0) begin
                        state_d = ST_REDIRECT;
                        cnt_d   = LAT3;
                    end
                end else begin
                    if (load_use) begin
                        stall_f_c = 1'b1;
                        stall_d_c = 1'b1;
                        flush_e_c = 1'b1;
                    end
                    if (mc_start_e)
                        state_d = ST_MC_WAIT;
                end
            end
            ST_REDIRECT: begin
                // Only bubbles are in E here, so pcsrc/mc_start/load-use are moot.
                flush_d_c = 1'b1;
                cnt_d     = cnt_q - 3'd1;
                if (cnt_q <= 3'd1)
                    state_d = ST_RUN;
            end
            ST_MC_WAIT: begin
                mc_busy_c = 1'b1;
                // Stalls release in the mc_done cycle so the result is captured.
                if (mc_done) begin
                    state_d = ST_RUN;
                end else begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    stall_e_c = 1'b1;
                    flush_m_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Outputs are forced low combinationally while reset is held, including
    // the forwarding selects which otherwise depend only on inputs.
    assign fwd_e     = rst ? fwd_c : '0;
    assign stall_f   = rst & stall_f_c;
    assign stall_d   = rst & stall_d_c;
    assign stall_e   = rst & stall_e_c;
    assign flush_d   = rst & flush_d_c;
    assign flush_e   = rst & flush_e_c;
    assign flush_m   = rst & flush_m_c;
    assign mc_busy   = rst & mc_busy_c;
    assign dbg_state = rst ? state_q : ST_RUN;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_f) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_d) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int NUM_SRC = 2;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NUM_SRC*REG_AW-1:0] rs_d = '0, rs_e = '0;
  logic [REG_AW-1:0] rd_e = '0, rd_m = '0, rd_w = '0;
  logic memtoreg_e = 0, regwrite_m = 0, regwrite_w = 0;
  logic pcsrc_e = 0, mc_start_e = 0, mc_done = 0;
  logic [NUM_SRC*2-1:0] fwd_e;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy;
  logic [1:0] dbg_state;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .REDIRECT_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rs_e(rs_e), .rd_e(rd_e),
    .memtoreg_e(memtoreg_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .rd_w(rd_w), .regwrite_w(regwrite_w), .pcsrc_e(pcsrc_e),
    .mc_start_e(mc_start_e), .mc_done(mc_done), .fwd_e(fwd_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .mc_busy(mc_busy), .dbg_state(dbg_state)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ctl order: stall_f stall_d stall_e flush_d flush_e flush_m mc_busy
  wire [6:0] ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Redirect is modelled as "how many more flush-only cycles remain", the
  // multi-cycle op as "waiting for done". Expected outputs follow directly.
  int m_redir_left = 0, n_redir_left = 0;
  bit m_mc_wait = 0, n_mc_wait = 0;
  int m_stalls = 0, n_stalls = 0, m_flushes = 0, n_flushes = 0;

  function automatic logic [1:0] fwd_sel(input int k);
    logic [REG_AW-1:0] s;
    s = rs_e[k*REG_AW +: REG_AW];
    if (regwrite_m && rd_m != 0 && rd_m == s) return 2'b10;
    if (regwrite_w && rd_w != 0 && rd_w == s) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    logic [3:0] e_fwd;
    logic [6:0] e_ctl;
    bit lu;
    e_fwd = '0;
    e_ctl = '0;
    lu = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      e_fwd[k*2 +: 2] = fwd_sel(k);
      if (memtoreg_e && rd_e != 0 && rd_e == rs_d[k*REG_AW +: REG_AW]) lu = 1;
    end
    n_redir_left = m_redir_left;
    n_mc_wait = m_mc_wait;
    if (!rst) begin
      e_fwd = '0;
      n_redir_left = 0;
      n_mc_wait = 0;
    end else if (m_mc_wait) begin
      e_ctl = mc_done ? 7'b0000001 : 7'b1110011;
      n_mc_wait = !mc_done;
    end else if (m_redir_left > 0) begin
      e_ctl = 7'b0001000;
      n_redir_left = m_redir_left - 1;
    end else if (pcsrc_e) begin
      e_ctl = 7'b0001100;
      n_redir_left = LAT;
    end else begin
      if (lu) e_ctl = 7'b1100100;
      if (mc_start_e) n_mc_wait = 1;
    end
    n_stalls = m_stalls + int'(e_ctl[6]);
    n_flushes = m_flushes + int'(e_ctl[3]);
    check("fwd_e", 32'(fwd_e), 32'(e_fwd));
    check("ctl", 32'(ctl), 32'(e_ctl));
`ifdef HAZ_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stalls);
    check("flush_cnt", flush_cnt, m_flushes);
`endif
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_redir_left <= 0;
      m_mc_wait <= 0;
      m_stalls <= 0;
      m_flushes <= 0;
    end else begin
      m_redir_left <= n_redir_left;
      m_mc_wait <= n_mc_wait;
      m_stalls <= n_stalls;
      m_flushes <= n_flushes;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_d = '0; rs_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    memtoreg_e = 0; regwrite_m = 0; regwrite_w = 0;
    pcsrc_e = 0; mc_start_e = 0; mc_done = 0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    clear_inputs();
    rst = 0;
    @(negedge clk);
    check("reset_ctl", 32'(ctl), 32'h0);
    next_cycle();
    rst = 1;

    // Forwarding priority and x0
    next_cycle();
    regwrite_m = 1; rd_m = 5; regwrite_w = 1; rd_w = 5; rs_e = {5'd5, 5'd5};
    @(negedge clk); check("fwd_m_prio", 32'(fwd_e), 32'b1010);
    next_cycle(); rd_m = 0;
    @(negedge clk); check("fwd_w", 32'(fwd_e), 32'b0101);
    next_cycle(); rd_w = 0;
    @(negedge clk); check("fwd_none", 32'(fwd_e), 32'b0000);

    // Load-use on operand 1
    next_cycle(); clear_inputs();
    memtoreg_e = 1; rd_e = 7; rs_d = {5'd7, 5'd3};
    @(negedge clk); check("lu_hit", 32'({stall_f, stall_d, flush_e}), 32'b111);
    next_cycle(); memtoreg_e = 0;
    @(negedge clk); check("lu_one_cycle", 32'({stall_f, stall_d, flush_e}), 32'b000);
    next_cycle(); memtoreg_e = 1; rd_e = 0; rs_d = '0;
    @(negedge clk); check("lu_x0", 32'({stall_f, stall_d, flush_e}), 32'b000);

    // Redirect (LAT=2) with a coincident load-use
    next_cycle(); clear_inputs();
    memtoreg_e = 1; rd_e = 7; rs_d = {5'd7, 5'd0}; pcsrc_e = 1;
    @(negedge clk); check("redir_c0", 32'(ctl), 32'b0001100);
    next_cycle(); pcsrc_e = 0;
    @(negedge clk); check("redir_c1", 32'(ctl), 32'b0001000);
    next_cycle();
    @(negedge clk); check("redir_c2", 32'(ctl), 32'b0001000);
    next_cycle(); clear_inputs();
    @(negedge clk); check("redir_done", 32'(ctl), 32'b0000000);

    // Multi-cycle op: start, four wait cycles (pcsrc ignored), done
    next_cycle(); mc_start_e = 1;
    @(negedge clk); check("mc_start", 32'(ctl), 32'b0000000);
    next_cycle(); mc_start_e = 0; pcsrc_e = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("mc_wait", 32'(ctl), 32'b1110011);
      next_cycle(); pcsrc_e = 0;
    end
    mc_done = 1;
    @(negedge clk); check("mc_done", 32'(ctl), 32'b0000001);
    next_cycle(); mc_done = 0;
    @(negedge clk); check("mc_after", 32'(ctl), 32'b0000000);

    // Reset mid-MC_WAIT
    next_cycle(); mc_start_e = 1; regwrite_m = 1; rd_m = 5; rs_e = {5'd5, 5'd5};
    next_cycle(); mc_start_e = 0;
    @(posedge clk); #3; rst = 0; #1;
    check("rst_async", 32'({fwd_e, ctl}), 32'h0);
    next_cycle(); rst = 1; clear_inputs();
    next_cycle(); mc_done = 1;
    @(negedge clk); check("rst_mc_done", 32'(ctl), 32'b0000000);
    next_cycle(); mc_done = 0;

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rs_d = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rs_e = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rd_e = 5'($urandom_range(0, 3));
      rd_m = 5'($urandom_range(0, 3));
      rd_w = 5'($urandom_range(0, 3));
      memtoreg_e = ($urandom_range(0, 1) == 1);
      regwrite_m = ($urandom_range(0, 2) != 0);
      regwrite_w = ($urandom_range(0, 2) != 0);
      pcsrc_e = ($urandom_range(0, 9) == 0);
      mc_start_e = ($urandom_range(0, 9) == 0);
      mc_done = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 399) != 0);
    end
    next_cycle();
    rst = 1;
    clear_inputs();
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
